hourglass_sort_scheduler: RTL and testbench

Shares one `hourglass_sorting_module` between `NUM_REQUESTERS` clients. Each client presents a full key vector. A round-robin arbiter grants one client at a time, and the block issues the sorter `load` pulse. It then forwards exactly `NUMBER_OF_ELEMENTS` sorted beats downstream, tagged with the client id and a `last` flag, before granting the next client. It sits directly in front of the sorter and owns its `load`, `in_keys` and output `ready`.

---
 rtl/hourglass_sort_pkg.sv | 19 +
 rtl/hourglass_sort_scheduler_rr_arbiter.sv | 37 +++
 rtl/hourglass_sort_scheduler.sv | 98 +++++++++
 tb/tb_hourglass_sort_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hourglass_sort_pkg.sv
// Shared types and helpers for the hourglass sort scheduler.
package hourglass_sort_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        DRAIN = ST_DRAIN
    } sched_state_t;

    // $clog2 that never returns zero, so single-entry counters still get a bit.
    function automatic int CNT_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hourglass_sort_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request after last_grant, wrapping.
module rr_arbiter
    import hourglass_sort_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_WIDTH       = 2
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]       last_grant,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [ID_WIDTH-1:0]       grant_id,
    output logic                      any
);

    localparam int IW = CNT_W(NUM_REQUESTERS);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQUESTERS);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_WIDTH'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/hourglass_sort_scheduler.sv
// Time-shares one hourglass sorter between several clients: arbitrate, load, drain one vector.
module hourglass_sort_scheduler
    import hourglass_sort_pkg::*;
#(
    parameter int NUM_REQUESTERS     = 4,
    parameter int NUMBER_OF_ELEMENTS = 21,
    parameter int KEY_WIDTH          = 8,
    parameter int OUTPUT_INDEX_WIDTH = 5,
    parameter int ID_WIDTH           = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUM_REQUESTERS-1:0]                            req_valid,
    input  logic [NUM_REQUESTERS*NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0] req_keys,
    output logic [NUM_REQUESTERS-1:0]                            req_ready,
    output logic                                                 sort_load,
    output logic [NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0]              sort_keys,
    input  logic [KEY_WIDTH-1:0]                                 sort_key,
    input  logic [OUTPUT_INDEX_WIDTH-1:0]                        sort_index,
    input  logic                                                 sort_valid,
    output logic                                                 sort_ready,
    output logic [KEY_WIDTH-1:0]                                 axis_out_key,
    output logic [OUTPUT_INDEX_WIDTH-1:0]                        axis_out_index,
    output logic [ID_WIDTH-1:0]                                  axis_out_id,
    output logic                                                 axis_out_last,
    output logic                                                 axis_out_valid,
    input  logic                                                 axis_out_ready,
    output logic                                                 busy
);

    localparam int CW = CNT_W(NUMBER_OF_ELEMENTS);
    localparam int VW = NUMBER_OF_ELEMENTS * KEY_WIDTH;

    sched_state_t              state;
    logic [ID_WIDTH-1:0]       last_grant;
    logic [ID_WIDTH-1:0]       cur_id;
    logic [CW-1:0]             count;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [ID_WIDTH-1:0]       grant_id;
    logic                      any;
    logic                      in_idle, in_load, in_drain;
    logic                      beat, last_beat;

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS),
        .ID_WIDTH      (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_id  (grant_id),
        .any       (any)
    );

    // Combinational outputs are masked during reset so nothing leaks while the FSM is being cleared.
    assign in_idle   = !rst && (state == IDLE);
    assign in_load   = !rst && (state == LOAD);
    assign in_drain  = !rst && (state == DRAIN);
    assign beat      = in_drain && sort_valid && axis_out_ready;
    assign last_beat = (count == CW'(NUMBER_OF_ELEMENTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_WIDTH'(NUM_REQUESTERS - 1);
            cur_id     <= '0;
            count      <= '0;
            sort_keys  <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    sort_keys  <= req_keys[grant_id*VW +: VW];
                    cur_id     <= grant_id;
                    last_grant <= grant_id;
                    count      <= '0;
                    state      <= LOAD;
                end
                LOAD: state <= DRAIN;
                DRAIN: if (beat) begin
                    if (last_beat) state <= IDLE;
                    else           count <= count + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = in_idle ? grant : '0;
    assign sort_load      = in_load;
    assign sort_ready     = in_drain && axis_out_ready;
    assign axis_out_valid = in_drain && sort_valid;
    assign axis_out_key   = in_drain ? sort_key : '0;
    assign axis_out_index = in_drain ? sort_index : '0;
    assign axis_out_id    = cur_id;
    assign axis_out_last  = in_drain && last_beat;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_hourglass_sort_scheduler.sv
// Self-checking bench: behavioural sorter stand-in plus a rank-based reference for each vector.
module tb_hourglass_sort_scheduler;

    localparam int NR  = 4;
    localparam int NE  = 21;
    localparam int KW  = 8;
    localparam int OW  = 5;
    localparam int IDW = 2;
    localparam int VW  = NE * KW;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*VW-1:0]  req_keys;
    logic [NR-1:0]     req_ready;
    logic              sort_load;
    logic [VW-1:0]     sort_keys;
    logic [KW-1:0]     sort_key;
    logic [OW-1:0]     sort_index;
    logic              sort_valid;
    logic              sort_ready;
    logic [KW-1:0]     axis_out_key;
    logic [OW-1:0]     axis_out_index;
    logic [IDW-1:0]    axis_out_id;
    logic              axis_out_last;
    logic              axis_out_valid;
    logic              axis_out_ready;
    logic              busy;

    int tests;
    int fails;
    int last_g;
    logic [KW-1:0] kv [NR][NE];

    hourglass_sort_scheduler #(
        .NUM_REQUESTERS    (NR),
        .NUMBER_OF_ELEMENTS(NE),
        .KEY_WIDTH         (KW),
        .OUTPUT_INDEX_WIDTH(OW),
        .ID_WIDTH          (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_keys      (req_keys),
        .req_ready     (req_ready),
        .sort_load     (sort_load),
        .sort_keys     (sort_keys),
        .sort_key      (sort_key),
        .sort_index    (sort_index),
        .sort_valid    (sort_valid),
        .sort_ready    (sort_ready),
        .axis_out_key  (axis_out_key),
        .axis_out_index(axis_out_index),
        .axis_out_id   (axis_out_id),
        .axis_out_last (axis_out_last),
        .axis_out_valid(axis_out_valid),
        .axis_out_ready(axis_out_ready),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_keys = '0;
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < NE; i++)
                req_keys[(r*NE+i)*KW +: KW] = kv[r][i];
    end

    // Sorter stand-in: stable sort on load, then streams beats with random bubbles.
    logic [KW-1:0] tk [NE];
    logic [OW-1:0] ti [NE];
    logic [KW-1:0] srt_k [NE];
    logic [OW-1:0] srt_i [NE];
    int            srt_pos;
    logic          srt_act;
    logic          srt_bub;

    always_comb begin
        logic [KW-1:0] t;
        logic [OW-1:0] u;
        t = '0;
        u = '0;
        for (int i = 0; i < NE; i++) begin
            tk[i] = sort_keys[i*KW +: KW];
            ti[i] = OW'(i);
        end
        for (int p = 0; p < NE; p++)
            for (int j = 0; j < NE-1; j++)
                if (tk[j] > tk[j+1]) begin
                    t = tk[j]; tk[j] = tk[j+1]; tk[j+1] = t;
                    u = ti[j]; ti[j] = ti[j+1]; ti[j+1] = u;
                end
    end

    always @(posedge clk) begin
        srt_bub <= ($urandom_range(0, 3) == 0);
        if (rst) begin
            srt_act <= 1'b0;
            srt_pos <= 0;
        end else if (sort_load) begin
            srt_k   <= tk;
            srt_i   <= ti;
            srt_pos <= 0;
            srt_act <= 1'b1;
        end else if (sort_valid && sort_ready) begin
            srt_pos <= srt_pos + 1;
            if (srt_pos == NE-1) srt_act <= 1'b0;
        end
    end

    assign sort_valid = srt_act && !srt_bub && (srt_pos < NE);
    assign sort_key   = (srt_pos < NE) ? srt_k[srt_pos] : '0;
    assign sort_index = (srt_pos < NE) ? srt_i[srt_pos] : '0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    function automatic int rr_pick(input logic [NR-1:0] m, input int last);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (last + k) % NR;
            if (((m >> j) & NR'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic rand_keys(input int r);
        for (int i = 0; i < NE; i++) kv[r][i] = KW'($urandom_range(0, 40));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        axis_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_g = NR-1;
    endtask

    // Serves one vector starting in the grant cycle; abort_at >= 0 stops after that many beats.
    task automatic serve(input int pct, input bit hold, input int abort_at);
        int exp_id, beats, cycles, rank;
        bit mirror_bad;
        logic [KW-1:0] ek [NE];
        logic [OW-1:0] ei [NE];
        exp_id = rr_pick(req_valid, last_g);
        #1;
        tests++;
        if (exp_id < 0 || req_ready !== NR'(1 << exp_id) || busy !== 1'b0) begin
            fails++;
            $display("FAIL grant: req_ready=%b busy=%b, required client %0d busy=0", req_ready, busy, exp_id);
            return;
        end
        for (int i = 0; i < NE; i++) begin
            rank = 0;
            for (int j = 0; j < NE; j++)
                if (kv[exp_id][j] < kv[exp_id][i] || (kv[exp_id][j] == kv[exp_id][i] && j < i)) rank++;
            ek[rank] = kv[exp_id][i];
            ei[rank] = OW'(i);
        end
        last_g = exp_id;
        @(negedge clk);
        if (!hold) begin
            req_valid[exp_id] = 1'b0;
            rand_keys(exp_id);
        end
        axis_out_ready = 1'b1;
        #1;
        tests++;
        if ({sort_load, sort_ready, axis_out_valid, busy, req_ready} !== {4'b1001, NR'(0)}) begin
            fails++;
            $display("FAIL load_cycle: load=%b sready=%b ovalid=%b busy=%b rr=%b, required 1 0 0 1 0",
                     sort_load, sort_ready, axis_out_valid, busy, req_ready);
        end
        beats = 0;
        cycles = 0;
        mirror_bad = 1'b0;
        while (beats < NE && beats != abort_at && cycles < 3000) begin
            @(negedge clk);
            axis_out_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (sort_ready !== axis_out_ready) mirror_bad = 1'b1;
            if (axis_out_valid === 1'b1 && axis_out_ready) begin
                tests++;
                if (axis_out_key !== ek[beats] || axis_out_index !== ei[beats] ||
                    axis_out_id !== IDW'(exp_id) || axis_out_last !== (beats == NE-1)) begin
                    fails++;
                    $display("FAIL beat %0d: key=%0d idx=%0d id=%0d last=%b, required key=%0d idx=%0d id=%0d last=%b",
                             beats, axis_out_key, axis_out_index, axis_out_id, axis_out_last,
                             ek[beats], ei[beats], exp_id, (beats == NE-1));
                end
                beats++;
            end
            cycles++;
        end
        tests++;
        if (mirror_bad) begin
            fails++;
            $display("FAIL ready_mirror: sort_ready differed from axis_out_ready in drain (client %0d)", exp_id);
        end
        if (abort_at >= 0) return;
        tests++;
        if (beats != NE) begin
            fails++;
            $display("FAIL beat_count: got %0d beats, required %0d (client %0d)", beats, NE, exp_id);
        end
        @(negedge clk);
        axis_out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({req_ready, sort_load, sort_ready, axis_out_valid, axis_out_last, busy} !== '0 ||
            axis_out_key !== '0 || axis_out_index !== '0 || axis_out_id !== '0 || sort_keys !== '0) begin
            fails++;
            $display("FAIL %s: rr=%b load=%b sready=%b ovalid=%b last=%b busy=%b key=%0d idx=%0d id=%0d, required all 0",
                     name, req_ready, sort_load, sort_ready, axis_out_valid, axis_out_last, busy,
                     axis_out_key, axis_out_index, axis_out_id);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        req_valid = '1;
        axis_out_ready = 1'b1;
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        axis_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || sort_load !== 1'b0 || sort_keys !== '0) begin
            fails++;
            $display("FAIL idle_hold: busy=%b load=%b, required 0 0 with keys unchanged", busy, sort_load);
        end
    endtask

    task automatic test_single_client();
        @(negedge clk);
        rand_keys(2);
        kv[2][0] = 8'd3; kv[2][1] = 8'd1; kv[2][2] = 8'd2; kv[2][3] = 8'd0;
        req_valid = 4'b0100;
        serve(100, 1'b0, -1);
    endtask

    task automatic test_all_four();
        do_reset();
        req_valid = '1;
        repeat (NR) serve(100, 1'b0, -1);
    endtask

    task automatic test_fairness();
        @(negedge clk);
        req_valid = 4'b1001;
        repeat (4) serve(100, 1'b1, -1);
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 6; n++) begin
            req_valid = req_valid | NR'($urandom_range(1, (1 << NR) - 1));
            serve(30, 1'b0, -1);
        end
        while (req_valid != '0) serve(60, 1'b0, -1);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        req_valid = 4'b0010;
        serve(100, 1'b0, 10);
        rst = 1'b1;
        req_valid = 4'b0011;
        #1;
        tests++;
        if (req_ready !== '0 || axis_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_gate: rr=%b ovalid=%b, required 0 0", req_ready, axis_out_valid);
        end
        @(negedge clk);
        #1;
        check_all_zero("mid_reset");
        rst = 1'b0;
        last_g = NR-1;
        req_valid = 4'b0010;
        serve(100, 1'b0, -1);
        req_valid = 4'b0011;
        serve(100, 1'b0, -1);
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0100;
        serve(100, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("mid_reset_2");
        rst = 1'b0;
        last_g = NR-1;
        req_valid = 4'b1010;
        serve(100, 1'b0, -1);
        serve(50, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        axis_out_ready = 1'b0;
        tests = 0;
        fails = 0;
        last_g = NR-1;
        for (int r = 0; r < NR; r++) rand_keys(r);
        test_reset();
        test_single_client();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
